bcd_display_scan: RTL
=====================

# bcd_display_scan

Multiplexed seven-segment display scanner for packed BCD digits. Sits directly downstream of the cascaded decade counters: it captures their BCD outputs, buffers them tear-free, and drives one digit at a time with a programmable dwell. Decoding, leading-zero blanking and frame-boundary update are all handled here.

## Interface

- DIGITS, 4, number of BCD digits / anode lines (1..8)
- SCAN_DIV, 1000, clock cycles each digit is driven (>= 2)
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 never blanked)

- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- enable  in  1  scan enable; 0 = display dark
- din_valid  in  1  capture strobe for din
- din  in  4*DIGITS  packed BCD, digit 0 in din[3:0]
- an  out  DIGITS  one-hot digit select, active-high
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- frame_done  out  1  one-cycle pulse at end of each full scan frame

## Operation

- Registers: shadow (4*DIGITS), disp (4*DIGITS), pending, state, div_cnt (clog2(SCAN_DIV)), idx (clog2(DIGITS), min 1 bit).
- States: IDLE, SCAN.
  - IDLE: an=0, seg=0. A high enable moves to SCAN with div_cnt=0, idx=0.
  - SCAN: div_cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1 it returns to 0 and idx advances; idx wraps DIGITS-1 -> 0. Enable low returns to IDLE on the next edge with div_cnt=0 and idx=0.
- Capture:
  - In IDLE, din_valid loads shadow and disp together; pending stays 0.
  - In SCAN, din_valid loads shadow and sets pending. The last valid before the frame end wins.
- Frame end is the edge where idx wraps DIGITS-1 -> 0. On that edge:
  - frame_done=1 for one cycle.
  - If pending, then disp<=shadow and pending<=0.
  - If din_valid is also high, then disp<=din directly and pending<=0 (no second transfer).
- Decode (from disp digit idx):
  - 0..9 map to 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
  - 10..15 map to 40 (dash).
- Blanking: with BLANK_LZ=1, digit k>0 is blanked (seg=00, an still asserted) when digits k..DIGITS-1 of disp are all zero.
- Reset (any cycle, including mid-frame): state=IDLE; div_cnt, idx, shadow, disp, pending, an, seg and frame_done all 0.

## Timing

- an, seg and frame_done are registered. They reflect state/idx with one clock latency.
- Enable first seen high at edge t gives an=one-hot(0) from edge t+1.
- Each digit is driven for exactly SCAN_DIV cycles. One frame is DIGITS*SCAN_DIV cycles.
- Enable low at edge t gives an=0 and seg=0 from edge t+1. On re-enable, digit 0 gets a full slot.
- A value captured in SCAN becomes visible on the first digit of the next frame.
- A value captured in IDLE is visible on the first digit driven after enable.
- frame_done is never asserted in IDLE.

## Structure

- Package bcd_disp_pkg holds:
  - state enum {IDLE, SCAN};
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
- Sub-module bcd_to_seg: combinational 4-bit BCD to 7-segment decoder, instantiated once on the selected digit.
- Blanking and one-hot generation stay in the top module.

## Test plan

All scenarios use DIGITS=4 and SCAN_DIV=4.

- Reset: enable=1 with reset_n low for 2 cycles -> an=0, seg=00, frame_done=0. Scanning starts only after release.
- Basic scan: in IDLE, din=16'h0907 with din_valid, then enable. Required response for 4 cycles each:
  - an=0001, seg=07;
  - an=0010, seg=3F;
  - an=0100, seg=6F;
  - an=1000, seg=00 (blanked).
  - frame_done pulses on cycle 16.
- Tear-free update: din=16'h1234 with din_valid during slot 1 -> current frame is unchanged. The next frame shows digit 0 seg=66, digit 3 seg=06.
- Coincident capture: din_valid with 16'h0005 on the frame-end edge -> next frame shows 6D, 00, 00, 00. pending=0 afterwards, and no further change at the following frame end.
- Invalid digit: din=16'h000A -> digit 0 seg=40.
- Enable drop: enable low mid slot 2 -> an=0 and seg=00 next cycle. Re-enable gives an=0001 for a full 4 cycles.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment encodings for the multiplexed BCD display scanner.
package bcd_disp_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Capture-side and display-side signals of the BCD display scanner.
interface bcd_display_scan_if
    import bcd_disp_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);
    logic                      enable;
    logic                      din_valid;
    logic [DIGIT_W*DIGITS-1:0] din;
    logic [DIGITS-1:0]         an;
    logic [SEG_W-1:0]          seg;
    logic                      frame_done;

    modport master (
        output enable, din_valid, din,
        input  an, seg, frame_done
    );

    modport slave (
        input  enable, din_valid, din,
        output an, seg, frame_done
    );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0: seg_c = SEG_0;
            4'd1: seg_c = SEG_1;
            4'd2: seg_c = SEG_2;
            4'd3: seg_c = SEG_3;
            4'd4: seg_c = SEG_4;
            4'd5: seg_c = SEG_5;
            4'd6: seg_c = SEG_6;
            4'd7: seg_c = SEG_7;
            4'd8: seg_c = SEG_8;
            4'd9: seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed seven-segment scanner: tear-free BCD capture, per-digit dwell,
// leading-zero blanking and a frame-end pulse.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter bit          BLANK_LZ = 1'b1
)(
    input  logic             clock,
    input  logic             reset_n,
    bcd_display_scan_if.slave bus
);

    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DATA_W = DIGIT_W * DIGITS;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wrap_c;
    logic [DATA_W-1:0]   shadow_q, disp_q;
    logic                pending_q;
    logic [DIGITS-1:0]   an_q;
    logic [SEG_W-1:0]    seg_q;
    logic                frame_done_q;
    logic [DIGIT_W-1:0]  digit_c;
    logic [SEG_W-1:0]    dec_c;
    logic                blank_c;
    logic                zero_run;

    // State, dwell counter and digit index
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        wrap_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = SCAN;
                    div_d   = '0;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    div_d   = '0;
                    idx_d   = '0;
                end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                    div_d = '0;
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        idx_d  = '0;
                        wrap_c = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture: shadow buffers mid-frame writes, disp only changes at frame
    // boundaries (or when the scan is stopped) so a frame never tears.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
        end else if (state_q == IDLE) begin
            pending_q <= 1'b0;
            if (bus.din_valid) begin
                shadow_q <= bus.din;
                disp_q   <= bus.din;
            end
        end else begin
            if (bus.din_valid) begin
                shadow_q <= bus.din;
            end
            if (wrap_c || state_d == IDLE) begin
                pending_q <= 1'b0;
                if (bus.din_valid) begin
                    disp_q <= bus.din;
                end else if (pending_q) begin
                    disp_q <= shadow_q;
                end
            end else if (bus.din_valid) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign digit_c = disp_q[DIGIT_W*idx_q +: DIGIT_W];

    bcd_to_seg u_dec (
        .bcd   (digit_c),
        .seg_c (dec_c)
    );

    // A digit above 0 is blanked when it and every more-significant digit is zero
    always_comb begin
        zero_run = 1'b1;
        blank_c  = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (disp_q[DIGIT_W*k +: DIGIT_W] == '0);
            if (BLANK_LZ && zero_run && (idx_q == IDX_W'(k))) begin
                blank_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            an_q         <= '0;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= wrap_c;
            if (state_q == SCAN) begin
                an_q  <= DIGITS'(1) << idx_q;
                seg_q <= blank_c ? SEG_BLANK : dec_c;
            end else begin
                an_q  <= '0;
                seg_q <= SEG_BLANK;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;

endmodule
